// File: rtl/wallace_mult_pipe_pkg.sv
// Shared definitions for the pipelined Wallace-tree multiplier: operand
// mode encoding plus elaboration-time helpers that size the reduction tree.
package wallace_mult_pipe_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  // Rows left after 'lvl' levels of 3:2 compression, starting from r0 rows.
  // Every full group of three rows becomes two; leftover rows pass through.
  function automatic int unsigned tree_rows(int unsigned r0, int unsigned lvl);
    int unsigned r = r0;
    for (int unsigned k = 0; k < lvl; k++) begin
      r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  // Number of compression levels needed to reach two rows.
  function automatic int unsigned tree_levels(int unsigned r0);
    int unsigned r = r0;
    int unsigned n = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      n++;
    end
    return n;
  endfunction

  // Baugh-Wooley correction constant: ones at bit WIDTH and bit 2*WIDTH-1.
  function automatic bit bw_corr_bit(int unsigned width, int unsigned pos);
    return (pos == width) || (pos == 2 * width - 1);
  endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One row of N 3:2 compressors. The carry row is already weighted (shifted
// left by one); the carry out of the top bit is dropped, as the product is
// only defined modulo 2^N.
module wallace_csa_row #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = {(a_i[N-2:0] & b_i[N-2:0]) |
                    (a_i[N-2:0] & c_i[N-2:0]) |
                    (b_i[N-2:0] & c_i[N-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier with valid/ready handshakes and a
// per-transaction signed/unsigned mode. Stages: S1 operands, optional S2
// carry-save rows, S3 final sum. The whole pipe advances or holds as one.
module wallace_mult_pipe
  import wallace_mult_pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TREE_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  // WIDTH partial-product rows plus one row for the signed correction constant.
  localparam int unsigned R0     = WIDTH + 1;
  localparam int unsigned NLVL   = tree_levels(R0);

  logic              advance;
  logic              v1_q;
  logic [WIDTH-1:0]  a1_q;
  logic [WIDTH-1:0]  b1_q;
  mode_e             m1_q;
  logic              is_signed;

  logic [PROD_W-1:0] pp_rows [R0];
  logic [PROD_W-1:0] corr_row;
  logic [PROD_W-1:0] tree_sum;
  logic [PROD_W-1:0] tree_carry;

  logic              cpa_valid;
  logic [PROD_W-1:0] cpa_sum;
  logic [PROD_W-1:0] cpa_carry;

  logic              out_valid_q;
  logic [PROD_W-1:0] product_q;
  logic [PROD_W-1:0] product_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // S1: capture operands and mode on accept; valid bit tracks bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      m1_q <= MODE_UNSIGNED;
    end else if (advance) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q <= multiplicand;
        b1_q <= multiplier;
        m1_q <= signed_mode ? MODE_SIGNED : MODE_UNSIGNED;
      end
    end
  end

  assign is_signed = (m1_q == MODE_SIGNED);

  // Partial products; in signed mode the terms pairing exactly one operand
  // MSB with a non-MSB bit are inverted (Baugh-Wooley).
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [WIDTH-1:0] bits;
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      localparam bit INV = ((i == WIDTH - 1) != (j == WIDTH - 1));
      assign bits[j] = (a1_q[j] & b1_q[i]) ^ (is_signed & INV);
    end
    assign pp_rows[i] = PROD_W'(bits) << i;
  end

  for (genvar p = 0; p < PROD_W; p++) begin : g_corr
    localparam bit CB = bw_corr_bit(WIDTH, p);
    assign corr_row[p] = is_signed & CB;
  end
  assign pp_rows[WIDTH] = corr_row;

  // Wallace reduction: each level compresses groups of three rows to two.
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int unsigned RI = tree_rows(R0, l);
    localparam int unsigned RO = tree_rows(R0, l + 1);
    localparam int unsigned G  = RI / 3;
    logic [PROD_W-1:0] rows_in  [RI];
    logic [PROD_W-1:0] rows_out [RO];

    if (l == 0) begin : g_src
      assign rows_in = pp_rows;
    end else begin : g_src
      assign rows_in = g_lvl[l-1].rows_out;
    end

    for (genvar g = 0; g < G; g++) begin : g_csa
      wallace_csa_row #(.N(PROD_W)) u_row (
        .a_i     (rows_in[3*g]),
        .b_i     (rows_in[3*g+1]),
        .c_i     (rows_in[3*g+2]),
        .sum_o   (rows_out[2*g]),
        .carry_o (rows_out[2*g+1])
      );
    end

    for (genvar k = 0; k < RI - 3 * G; k++) begin : g_pass
      assign rows_out[2*G+k] = rows_in[3*G+k];
    end
  end

  assign tree_sum   = g_lvl[NLVL-1].rows_out[0];
  assign tree_carry = g_lvl[NLVL-1].rows_out[1];

  if (TREE_REG != 0) begin : g_tree_reg
    logic              v2_q;
    logic [PROD_W-1:0] sum2_q;
    logic [PROD_W-1:0] carry2_q;

    // S2: register the two carry-save rows ahead of the final adder.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_q     <= 1'b0;
        sum2_q   <= '0;
        carry2_q <= '0;
      end else if (advance) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sum2_q   <= tree_sum;
          carry2_q <= tree_carry;
        end
      end
    end

    assign cpa_valid = v2_q;
    assign cpa_sum   = sum2_q;
    assign cpa_carry = carry2_q;
  end else begin : g_tree_comb
    assign cpa_valid = v1_q;
    assign cpa_sum   = tree_sum;
    assign cpa_carry = tree_carry;
  end

  // Final carry-propagate add; carry out of the top bit is discarded.
  assign product_d = cpa_sum + cpa_carry;

  // S3: output register; product only updates when a valid result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else if (advance) begin
      out_valid_q <= cpa_valid;
      if (cpa_valid) begin
        product_q <= product_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: a WIDTH=8/TREE_REG=1 instance driven by
// directed vectors plus a random phase, and a WIDTH=4/TREE_REG=0 instance
// swept over every operand pair in both modes. Both are scoreboarded
// against plain integer multiplication.
module tb_wallace_mult_pipe;

  localparam int W   = 8;
  localparam int PW  = 16;
  localparam int W2  = 4;
  localparam int PW2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [PW-1:0] product;

  logic           rst2, iv2, ir2, m2, ov2, or2;
  logic [W2-1:0]  a2, b2;
  logic [PW2-1:0] p2;
  logic           done2 = 1'b0;

  wallace_mult_pipe #(.WIDTH(W), .TREE_REG(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(a), .multiplier(b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  wallace_mult_pipe #(.WIDTH(W2), .TREE_REG(0)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2),
    .multiplicand(a2), .multiplier(b2), .signed_mode(m2),
    .out_valid(ov2), .out_ready(or2), .product(p2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product: operands read as w-bit unsigned or two's complement.
  function automatic logic [63:0] mref(input int w, input logic [31:0] x,
                                       input logic [31:0] y, input logic m);
    longint sx, sy, p;
    sx = longint'(x);
    sy = longint'(y);
    if (m) begin
      if (x[w-1]) sx = sx - (longint'(1) << w);
      if (y[w-1]) sy = sy - (longint'(1) << w);
    end
    p = sx * sy;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Scoreboard for the main instance, sampled mid-cycle.
  logic [PW-1:0] expq[$];
  logic          stall_prev = 1'b0;
  logic [PW-1:0] prod_prev;
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_product", product, prod_prev);
      end
      if (in_valid && in_ready) expq.push_back(PW'(mref(W, a, b, signed_mode)));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra actual=%0h expected=none", product);
        end else begin
          chk("sb_product", product, expq.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      prod_prev  = product;
    end
  end

  // Scoreboard for the narrow instance.
  logic [PW2-1:0] expq2[$];
  always @(negedge clk) begin
    if (rst2) begin
      expq2.delete();
    end else begin
      if (iv2 && ir2) expq2.push_back(PW2'(mref(W2, a2, b2, m2)));
      if (ov2 && or2) begin
        if (expq2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb2_extra actual=%0h expected=none", p2);
        end else begin
          chk("sb2_product", p2, expq2.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    a = x;
    b = y;
    signed_mode = m;
    in_valid = 1'b1;
  endtask

  // Single op with out_ready high: check value and accept-to-valid latency.
  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                         input logic [PW-1:0] e, input string nm);
    int n;
    drive(x, y, m);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, product, e);
    chk({nm, "_lat"}, n, 3);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 5)
      0:       return '0;
      1:       return 8'h01;
      2:       return '1;
      3:       return 8'h80;
      default: return W'($urandom);
    endcase
  endfunction

  // Narrow instance: exhaustive sweep with random bubbles and backpressure.
  initial begin
    logic acc;
    int   guard;
    rst2 = 1'b1; iv2 = 1'b0; a2 = '0; b2 = '0; m2 = 1'b0; or2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b0;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          a2 = 4'(x); b2 = 4'(y); m2 = m[0]; iv2 = 1'b1;
          guard = 0;
          do begin
            @(negedge clk);
            acc = ir2;
            @(posedge clk);
            #1;
            or2 = ($urandom_range(0, 3) != 0);
            guard++;
          end while (!acc && guard < 100);
          if (!acc) chk("dut2_accept_timeout", 0, 1);
          iv2 = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    iv2 = 1'b0;
    or2 = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    done2 = 1'b1;
  end

  initial begin
    int            n, got, stale;
    int            idx[3];
    logic [PW-1:0] val[3];
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Basic op with latency.
    run_one(8'd9, 8'd10, 1'b0, 16'd90, "u9x10");
    repeat (3) tick();

    // Streaming: results on three consecutive cycles.
    drive(8'd9, 8'd10, 1'b0);
    got = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      case (k)
        1:       b = 8'd11;
        2:       b = 8'd1;
        default: in_valid = 1'b0;
      endcase
      if (out_valid && got < 3) begin
        idx[got] = k;
        val[got] = product;
        got++;
      end
    end
    chk("stream_count", got, 3);
    chk("stream_cyc0", idx[0], 3);
    chk("stream_cyc1", idx[1], 4);
    chk("stream_cyc2", idx[2], 5);
    chk("stream_val0", val[0], 90);
    chk("stream_val1", val[1], 99);
    chk("stream_val2", val[2], 9);

    // Signed and boundary vectors.
    run_one(8'hF9, 8'h0C, 1'b1, 16'hFFAC, "s_m7x12");
    run_one(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_sq");
    run_one(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_max_sq");
    run_one(8'h00, 8'h5A, 1'b0, 16'h0000, "u_zero");
    run_one(8'h00, 8'hFF, 1'b1, 16'h0000, "s_zero");
    run_one(8'h7F, 8'h80, 1'b1, 16'hC080, "s_max_x_min");
    run_one(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1_sq");
    run_one(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1x1");
    run_one(8'h80, 8'h7F, 1'b0, 16'h3F80, "u_128x127");
    tick();

    // Backpressure: fill three stages, stall five cycles, drain in order.
    out_ready = 1'b0;
    drive(8'd3, 8'd5, 1'b0);   tick();
    drive(8'd7, 8'd7, 1'b0);   tick();
    drive(8'd2, 8'd100, 1'b0); tick();
    drive(8'hFE, 8'd3, 1'b1);
    for (int s = 0; s < 5; s++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_frozen", product, 15);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_drain0", product, 49);
    tick();
    chk("bp_drain1", product, 200);
    tick();
    chk("bp_drain2", product, 16'hFFFA);
    chk("bp_drain2_valid", out_valid, 1);
    tick();
    chk("bp_empty", out_valid, 0);

    // Reset with results in flight.
    out_ready = 1'b0;
    drive(8'd5, 8'd6, 1'b0);   tick();
    drive(8'd11, 8'd13, 1'b0); tick();
    in_valid = 1'b0;
    tick();
    chk("rs_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rs_valid", out_valid, 0);
    chk("rs_product", product, 0);
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      tick();
      if (out_valid) stale++;
    end
    chk("rs_stale", stale, 0);
    run_one(8'd12, 8'd12, 1'b0, 16'd144, "rs_after");
    tick();

    // Random mixed-mode traffic with random bubbles and backpressure.
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      a           = pick();
      b           = pick();
      signed_mode = $urandom_range(0, 1) != 0;
      out_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("sb_drained", expq.size(), 0);

    n = 0;
    while (!done2 && n < 20000) begin
      tick();
      n++;
    end
    chk("dut2_done", done2, 1);
    chk("sb2_drained", expq2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
